// File: rtl/tftp_pkg.sv
// rtl/tftp_pkg.sv - TFTP opcodes, header constants and FSM state encoding shared by tftp_encode/tftp_decode (TFTP_ERROR_EN adds ERR_* states)
package tftp_pkg;

  localparam logic [15:0] OPC_RRQ   = 16'd1;
  localparam logic [15:0] OPC_DATA  = 16'd3;
  localparam logic [15:0] OPC_ACK   = 16'd4;
  localparam logic [15:0] OPC_ERROR = 16'd5;

  localparam int TFTP_HDR_LEN = 4;
  localparam int MAX_PAYLOAD  = 512;

  // Each state names the byte currently presented on the stream.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPC_HI,
    ST_OPC_LO,
    ST_BLK_HI,
    ST_BLK_LO,
    ST_DATA
`ifdef TFTP_ERROR_EN
    ,
    ST_ERR_OPC_HI,
    ST_ERR_OPC_LO,
    ST_ERR_CODE_HI,
    ST_ERR_CODE_LO,
    ST_ERR_NUL
`endif
  } tftp_state_e;

  // Oversized requests are sent as a full block rather than rejected.
  function automatic logic [9:0] clamp_len(input logic [9:0] len, input logic [9:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/tftp_encode_if.sv
// rtl/tftp_encode_if.sv - transmit byte stream and block-buffer read port of the TFTP encoder
interface tftp_encode_if #(
  parameter int ADDR_W = 9
);

  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (
    output tx_data, tx_valid, tx_last, mem_ren, mem_addr,
    input  tx_ready, mem_rdata
  );

  modport slave (
    input  tx_data, tx_valid, tx_last, mem_ren, mem_addr,
    output tx_ready, mem_rdata
  );

endinterface

// File: rtl/tftp_tx_skid.sv
// rtl/tftp_tx_skid.sv - 2-entry 8-bit FIFO with occupancy, absorbs block-buffer read latency
module tftp_tx_skid (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [1:0] occ
);

  logic [7:0] slot0;
  logic [7:0] slot1;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  assign head = rd_ptr ? slot1 : slot0;
  assign occ  = count;

  // Ring of two slots; push and pop may happen in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0  <= 8'h00;
      slot1  <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= push_data;
        else        slot0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tftp_encode.sv
// rtl/tftp_encode.sv - TFTP DATA packet serialiser (ERROR packets when TFTP_ERROR_EN is defined)
module tftp_encode
  import tftp_pkg::*;
#(
  parameter int MAX_PAYLOAD = 512,
  parameter int ADDR_W      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] tid,
  input  logic [15:0] block_no,
  input  logic [9:0]  length,
`ifdef TFTP_ERROR_EN
  input  logic        err_start,
  input  logic [15:0] err_code,
`endif
  output logic [15:0] udp_dst,
  output logic [10:0] tftp_len,
  output logic        busy,
  output logic        done,
  tftp_encode_if.master bus
);

  localparam logic [9:0] MAX_LEN = 10'(MAX_PAYLOAD);

  tftp_state_e state;
  logic [15:0] word_q;     // block number, or error code for ERROR packets
  logic [9:0]  len_q;      // clamped payload length of the packet in flight
  logic [9:0]  byte_cnt;   // index of the payload byte on tx_data
  logic [9:0]  rd_cnt;     // reads issued this packet
  logic        rd_pend;    // read issued last cycle, data on mem_rdata now
  logic [9:0]  len_clamped;
  logic        pkt_go;
  logic        xfer;
  logic        rd_state;
  logic        take;
  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_head;
  logic [1:0]  fifo_occ;
  logic [7:0]  next_byte;
  logic [2:0]  buffered;

  assign len_clamped = clamp_len(length, MAX_LEN);
`ifdef TFTP_ERROR_EN
  logic err_go;
  assign err_go = (state == ST_IDLE) && err_start;
  assign pkt_go = (state == ST_IDLE) && start && !err_start;
`else
  assign pkt_go = (state == ST_IDLE) && start;
`endif

  assign xfer     = bus.tx_valid && bus.tx_ready;
  assign rd_state = (state == ST_BLK_HI) || (state == ST_BLK_LO) || (state == ST_DATA);

  // A payload byte is consumed whenever the byte leaving is followed by another payload byte.
  assign take = xfer && (((state == ST_BLK_LO) && (len_q != 10'd0)) ||
                         ((state == ST_DATA) && !bus.tx_last));

  // Bypass the FIFO when it is empty so the stream has no bubble at full rate.
  assign next_byte = (fifo_occ == 2'd0) ? bus.mem_rdata : fifo_head;
  assign fifo_pop  = take && (fifo_occ != 2'd0);
  assign fifo_push = rd_pend && !(take && (fifo_occ == 2'd0));

  assign buffered     = {1'b0, fifo_occ} + {2'b00, rd_pend};
  assign bus.mem_ren  = rd_state && (rd_cnt < len_q) && (buffered < 3'd2);
  assign bus.mem_addr = rd_cnt[ADDR_W-1:0];

  tftp_tx_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.mem_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .occ       (fifo_occ)
  );

  // Read address counter and in-flight flag for the one-cycle RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt  <= 10'd0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= bus.mem_ren;
      if (pkt_go)           rd_cnt <= 10'd0;
      else if (bus.mem_ren) rd_cnt <= rd_cnt + 10'd1;
    end
  end

  // Packet FSM: latches request fields and registers every stream output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
      bus.tx_last  <= 1'b0;
      word_q       <= 16'h0000;
      len_q        <= 10'd0;
      byte_cnt     <= 10'd0;
      udp_dst      <= 16'h0000;
      tftp_len     <= 11'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef TFTP_ERROR_EN
          if (err_go) begin
            state        <= ST_ERR_OPC_HI;
            bus.tx_data  <= OPC_ERROR[15:8];
            bus.tx_valid <= 1'b1;
            bus.tx_last  <= 1'b0;
            word_q       <= err_code;
            len_q        <= 10'd0;
            udp_dst      <= tid;
            tftp_len     <= 11'(TFTP_HDR_LEN + 1);  // header + NUL of empty message
            busy         <= 1'b1;
          end else
`endif
          if (pkt_go) begin
            state        <= ST_OPC_HI;
            bus.tx_data  <= OPC_DATA[15:8];
            bus.tx_valid <= 1'b1;
            bus.tx_last  <= 1'b0;
            word_q       <= block_no;
            len_q        <= len_clamped;
            udp_dst      <= tid;
            tftp_len     <= 11'(len_clamped) + 11'(TFTP_HDR_LEN);
            busy         <= 1'b1;
          end
        end
        ST_OPC_HI: if (xfer) begin
          state       <= ST_OPC_LO;
          bus.tx_data <= OPC_DATA[7:0];
        end
        ST_OPC_LO: if (xfer) begin
          state       <= ST_BLK_HI;
          bus.tx_data <= word_q[15:8];
        end
        ST_BLK_HI: if (xfer) begin
          state       <= ST_BLK_LO;
          bus.tx_data <= word_q[7:0];
          bus.tx_last <= (len_q == 10'd0);
        end
        ST_BLK_LO: if (xfer) begin
          if (len_q == 10'd0) begin
            state        <= ST_IDLE;
            bus.tx_valid <= 1'b0;
            bus.tx_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            state       <= ST_DATA;
            bus.tx_data <= next_byte;
            bus.tx_last <= (len_q == 10'd1);
            byte_cnt    <= 10'd0;
          end
        end
        ST_DATA: if (xfer) begin
          if (bus.tx_last) begin
            state        <= ST_IDLE;
            bus.tx_valid <= 1'b0;
            bus.tx_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            bus.tx_data <= next_byte;
            bus.tx_last <= ((byte_cnt + 10'd1) == (len_q - 10'd1));
            byte_cnt    <= byte_cnt + 10'd1;
          end
        end
`ifdef TFTP_ERROR_EN
        ST_ERR_OPC_HI: if (xfer) begin
          state       <= ST_ERR_OPC_LO;
          bus.tx_data <= OPC_ERROR[7:0];
        end
        ST_ERR_OPC_LO: if (xfer) begin
          state       <= ST_ERR_CODE_HI;
          bus.tx_data <= word_q[15:8];
        end
        ST_ERR_CODE_HI: if (xfer) begin
          state       <= ST_ERR_CODE_LO;
          bus.tx_data <= word_q[7:0];
        end
        ST_ERR_CODE_LO: if (xfer) begin
          state       <= ST_ERR_NUL;
          bus.tx_data <= 8'h00;
          bus.tx_last <= 1'b1;
        end
        ST_ERR_NUL: if (xfer) begin
          state        <= ST_IDLE;
          bus.tx_valid <= 1'b0;
          bus.tx_last  <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b1;
        end
`endif
        default: begin
          state        <= ST_IDLE;
          bus.tx_valid <= 1'b0;
          bus.tx_last  <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tftp_encode.sv
// tb/tb_tftp_encode.sv - self-checking bench for tftp_encode against a packet-level reference model
module tb_tftp_encode;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tid = 16'h0;
  logic [15:0] block_no = 16'h0;
  logic [9:0]  length = 10'd0;
  logic [15:0] udp_dst;
  logic [10:0] tftp_len;
  logic        busy;
  logic        done;
`ifdef TFTP_ERROR_EN
  logic        err_start = 1'b0;
  logic [15:0] err_code = 16'h0;
`endif

  tftp_encode_if #(.ADDR_W(9)) bus ();

  tftp_encode #(.MAX_PAYLOAD(512), .ADDR_W(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tid      (tid),
    .block_no (block_no),
    .length   (length),
`ifdef TFTP_ERROR_EN
    .err_start(err_start),
    .err_code (err_code),
`endif
    .udp_dst  (udp_dst),
    .tftp_len (tftp_len),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [512];
  always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;

  bq_t got_d;
  bit  got_l[$];
  int  n_ren, ren_idx, addr_viol, stall_viol, bubbles, dones, last_cnt, last_idx;
  bit  done_busy, first_valid, timeout;
  logic [7:0] first_data;
  logic [15:0] nxt_tid, nxt_blk;
  logic [9:0]  nxt_len;

  function automatic bq_t model_data(input logic [15:0] blk, input int len);
    bq_t q;
    int n = (len > 512) ? 512 : len;
    q.push_back(8'h00); q.push_back(8'h03); q.push_back(blk[15:8]); q.push_back(blk[7:0]);
    for (int i = 0; i < n; i++) q.push_back(mem[i]);
    return q;
  endfunction

  function automatic int first_diff(input bq_t e, input bq_t g);
    int n = (e.size() < g.size()) ? e.size() : g.size();
    for (int i = 0; i < n; i++) if (e[i] !== g[i]) return i;
    if (e.size() != g.size()) return n;
    return -1;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
  endtask

  task automatic clear_obs();
    got_d.delete(); got_l.delete();
    n_ren = 0; ren_idx = 0; addr_viol = 0; stall_viol = 0; bubbles = 0;
    dones = 0; last_cnt = 0; last_idx = -1; done_busy = 0;
  endtask

  task automatic kick(input logic [15:0] t, input logic [15:0] b, input logic [9:0] l);
    @(negedge clk);
    tid = t; block_no = b; length = l; start = 1'b1; ren_idx = 0;
  endtask

  // Drives tx_ready and records what the stream does; stops on done, a transfer count, or budget.
  task automatic run(input int pct, input int budget, input int stop_after, input int poke_at, input bit restart);
    int cyc = 0, xfers = 0, need = restart ? 2 : 1;
    bit prev_stall = 0, in_pkt = 0, prev_l = 0;
    logic [7:0] prev_d = 8'h00;
    timeout = 1;
    while (cyc < budget) begin
      @(negedge clk);
      bus.tx_ready = ($urandom_range(0, 99) < pct);
      start = 1'b0;
`ifdef TFTP_ERROR_EN
      err_start = 1'b0;
`endif
      #1;
      cyc++;
      if (cyc == 1) begin first_valid = bus.tx_valid; first_data = bus.tx_data; end
      if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_d || bus.tx_last !== prev_l)) stall_viol++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_d = bus.tx_data; prev_l = bus.tx_last;
      if (in_pkt && !bus.tx_valid) bubbles++;
      if (bus.tx_valid) in_pkt = 1;
      if (bus.mem_ren) begin
        if (bus.mem_addr !== ren_idx[8:0]) addr_viol++;
        ren_idx++; n_ren++;
      end
      if (done) begin
        dones++;
        if (busy) done_busy = 1;
        if (dones == need) begin timeout = 0; break; end
        if (restart) begin
          tid = nxt_tid; block_no = nxt_blk; length = nxt_len; start = 1'b1; ren_idx = 0;
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        got_d.push_back(bus.tx_data);
        got_l.push_back(bus.tx_last);
        if (bus.tx_last) begin
          last_cnt++;
          if (last_idx < 0) last_idx = xfers;
          in_pkt = 0;
        end
        xfers++;
        if (stop_after != 0 && xfers == stop_after) begin timeout = 0; break; end
      end
      if (cyc == poke_at) begin
        tid = 16'hBEEF; block_no = 16'h7777; length = 10'd1; start = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    checks++; if (bus.tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last got %b want 0", bus.tx_last); end
    checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL reset_mem_ren got %b want 0", bus.mem_ren); end
    checks++; if (bus.mem_addr !== 9'd0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", bus.mem_addr); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (udp_dst !== 16'h0 || tftp_len !== 11'd0) begin errors++; $display("FAIL reset_latches got %h/%0d want 0/0", udp_dst, tftp_len); end
  endtask

  task automatic test_full_packet();
    bq_t exp;
    int d;
    fill_mem(); clear_obs();
    exp = model_data(16'h0001, 512);
    kick(16'h0400, 16'h0001, 10'd512);
    run(100, 2000, 0, 0, 0);
    d = first_diff(exp, got_d);
    checks++; if (timeout) begin errors++; $display("FAIL full_timeout got no done want done"); end
    checks++; if (first_valid !== 1'b1 || first_data !== 8'h00) begin errors++; $display("FAIL full_latency got v=%b d=%h want v=1 d=00", first_valid, first_data); end
    checks++; if (d != -1) begin errors++; $display("FAIL full_bytes diff at %0d got %0d bytes want %0d", d, got_d.size(), exp.size()); end
    checks++; if (last_cnt != 1 || last_idx != 515) begin errors++; $display("FAIL full_last got cnt=%0d idx=%0d want 1/515", last_cnt, last_idx); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL full_bubbles got %0d want 0", bubbles); end
    checks++; if (n_ren != 512 || addr_viol != 0) begin errors++; $display("FAIL full_reads got %0d (addr errs %0d) want 512/0", n_ren, addr_viol); end
    checks++; if (tftp_len !== 11'd516 || udp_dst !== 16'h0400) begin errors++; $display("FAIL full_latch got %0d/%h want 516/0400", tftp_len, udp_dst); end
    checks++; if (done_busy) begin errors++; $display("FAIL full_done_busy got busy=1 at done want 0"); end
  endtask

  task automatic test_zero_length();
    bq_t exp;
    int d;
    clear_obs();
    exp = model_data(16'h002A, 0);
    kick(16'h1234, 16'h002A, 10'd0);
    run(100, 100, 0, 0, 0);
    d = first_diff(exp, got_d);
    checks++; if (timeout || d != -1) begin errors++; $display("FAIL zero_bytes diff at %0d got %0d bytes want %0d", d, got_d.size(), exp.size()); end
    checks++; if (last_cnt != 1 || last_idx != 3) begin errors++; $display("FAIL zero_last got cnt=%0d idx=%0d want 1/3", last_cnt, last_idx); end
    checks++; if (n_ren != 0) begin errors++; $display("FAIL zero_reads got %0d want 0", n_ren); end
    checks++; if (tftp_len !== 11'd4) begin errors++; $display("FAIL zero_tftp_len got %0d want 4", tftp_len); end
  endtask

  task automatic test_stall();
    bq_t exp;
    int d;
    fill_mem(); clear_obs();
    exp = model_data(16'h5A5A, 5);
    kick(16'h0045, 16'h5A5A, 10'd5);
    run(50, 400, 0, 0, 0);
    d = first_diff(exp, got_d);
    checks++; if (timeout || d != -1) begin errors++; $display("FAIL stall_bytes diff at %0d got %0d bytes want %0d", d, got_d.size(), exp.size()); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable got %0d violations want 0", stall_viol); end
    checks++; if (n_ren != 5 || addr_viol != 0) begin errors++; $display("FAIL stall_reads got %0d (addr errs %0d) want 5/0", n_ren, addr_viol); end
    checks++; if (last_cnt != 1 || last_idx != 8) begin errors++; $display("FAIL stall_last got cnt=%0d idx=%0d want 1/8", last_cnt, last_idx); end
  endtask

  task automatic test_random();
    int lens[4];
    lens[0] = 10'h3FF; lens[1] = 1; lens[2] = 2; lens[3] = $urandom_range(3, 600);
    for (int k = 0; k < 4; k++) begin
      bq_t exp;
      int d, n;
      logic [15:0] b = 16'($urandom);
      fill_mem(); clear_obs();
      n = (lens[k] > 512) ? 512 : lens[k];
      exp = model_data(b, lens[k]);
      kick(16'($urandom), b, 10'(lens[k]));
      run($urandom_range(30, 100), 4000, 0, 0, 0);
      d = first_diff(exp, got_d);
      checks++; if (timeout || d != -1) begin errors++; $display("FAIL rand%0d_bytes len=%0d diff at %0d got %0d want %0d", k, lens[k], d, got_d.size(), exp.size()); end
      checks++; if (tftp_len !== 11'(n + 4)) begin errors++; $display("FAIL rand%0d_tftp_len got %0d want %0d", k, tftp_len, n + 4); end
      checks++; if (n_ren != n || addr_viol != 0 || stall_viol != 0) begin errors++; $display("FAIL rand%0d_reads got %0d (addr %0d stall %0d) want %0d/0/0", k, n_ren, addr_viol, stall_viol, n); end
      checks++; if (last_cnt != 1 || last_idx != n + 3) begin errors++; $display("FAIL rand%0d_last got cnt=%0d idx=%0d want 1/%0d", k, last_cnt, last_idx, n + 3); end
    end
  endtask

  task automatic test_reset_mid();
    bq_t exp;
    int d;
    fill_mem(); clear_obs();
    kick(16'h0777, 16'h0009, 10'd512);
    run(100, 2000, 104, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got v=%b busy=%b want 0/0", bus.tx_valid, busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    exp = model_data(16'h0010, 3);
    kick(16'h0888, 16'h0010, 10'd3);
    run(100, 100, 0, 0, 0);
    d = first_diff(exp, got_d);
    checks++; if (timeout || d != -1) begin errors++; $display("FAIL mid_next_bytes diff at %0d got %0d bytes want %0d", d, got_d.size(), exp.size()); end
    checks++; if (n_ren != 3 || tftp_len !== 11'd7) begin errors++; $display("FAIL mid_next_reads got %0d/%0d want 3/7", n_ren, tftp_len); end
  endtask

  task automatic test_start_ignored();
    bq_t exp;
    int d, extra = 0;
    fill_mem(); clear_obs();
    exp = model_data(16'h0100, 20);
    kick(16'h0ABC, 16'h0100, 10'd20);
    run(70, 500, 0, 6, 0);
    d = first_diff(exp, got_d);
    checks++; if (timeout || d != -1) begin errors++; $display("FAIL ign_bytes diff at %0d got %0d bytes want %0d", d, got_d.size(), exp.size()); end
    checks++; if (udp_dst !== 16'h0ABC || tftp_len !== 11'd24) begin errors++; $display("FAIL ign_latch got %h/%0d want 0abc/24", udp_dst, tftp_len); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.tx_valid || busy) extra++;
    end
    checks++; if (extra != 0 || dones != 1) begin errors++; $display("FAIL ign_one_packet got extra=%0d dones=%0d want 0/1", extra, dones); end
  endtask

  task automatic test_back_to_back();
    bq_t exp, e2;
    int d, l1, l2;
    fill_mem(); clear_obs();
    l1 = $urandom_range(1, 8); l2 = $urandom_range(0, 8);
    nxt_tid = 16'h2222; nxt_blk = 16'($urandom); nxt_len = 10'(l2);
    exp = model_data(16'h1111, l1);
    e2 = model_data(nxt_blk, l2);
    foreach (e2[i]) exp.push_back(e2[i]);
    kick(16'h3333, 16'h1111, 10'(l1));
    run(100, 200, 0, 0, 1);
    d = first_diff(exp, got_d);
    checks++; if (timeout || d != -1) begin errors++; $display("FAIL b2b_bytes diff at %0d got %0d bytes want %0d", d, got_d.size(), exp.size()); end
    checks++; if (udp_dst !== 16'h2222 || tftp_len !== 11'(l2 + 4) || last_cnt != 2) begin errors++; $display("FAIL b2b_second got %h/%0d lasts=%0d want 2222/%0d/2", udp_dst, tftp_len, last_cnt, l2 + 4); end
  endtask

`ifdef TFTP_ERROR_EN
  task automatic test_error();
    bq_t exp;
    int d;
    logic [15:0] code;
    for (int k = 0; k < 2; k++) begin
      clear_obs();
      code = (k == 0) ? 16'h0001 : 16'($urandom);
      exp.delete();
      exp.push_back(8'h00); exp.push_back(8'h05); exp.push_back(code[15:8]); exp.push_back(code[7:0]); exp.push_back(8'h00);
      @(negedge clk);
      err_code = code; err_start = 1'b1;
      if (k == 1) begin tid = 16'h0042; block_no = 16'h0001; length = 10'd7; start = 1'b1; end
      run(60, 200, 0, 0, 0);
      d = first_diff(exp, got_d);
      checks++; if (timeout || d != -1) begin errors++; $display("FAIL err%0d_bytes diff at %0d got %0d bytes want 5", k, d, got_d.size()); end
      checks++; if (last_cnt != 1 || last_idx != 4 || tftp_len !== 11'd5 || n_ren != 0) begin errors++; $display("FAIL err%0d_fields got last=%0d@%0d len=%0d reads=%0d want 1@4 5 0", k, last_cnt, last_idx, tftp_len, n_ren); end
    end
  endtask
`endif

  initial begin
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_full_packet();
    test_zero_length();
    test_stall();
    test_random();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
`ifdef TFTP_ERROR_EN
    test_error();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
